// File: rtl/demux_deser8.sv
// demux_deser8 - serial-to-parallel 1-to-8 demultiplexing receiver.
//
// Each accepted serial bit is written into the slot of an assembly register
// chosen by a slot counter (the receive side of a counter-driven 8:1 mux).
// Completed bytes go out through a one-entry register with valid/ready.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   sin         serial data bit
//   sin_valid   sin is valid this cycle
//   sin_start   (qualified by sin_valid) bit 0 of a new byte
//   q           completed byte, q[i] = bit accepted in slot i
//   q_valid     q holds an unconsumed byte
//   q_ready     consumer accepts q
//   sel         slot the next accepted bit goes to
//   overrun     sticky: a completed byte was dropped
//   parity_err  only with DEMUX_PARITY_EN: even-parity check of delivered byte
//
// Optional feature macro: DEMUX_PARITY_EN (9-bit frames, slot 8 = even parity,
// sel widens to 4 bits, parity_err port present).
module demux_deser8 (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sin_start,
  output logic [7:0]   q,
  output logic         q_valid,
  input  logic         q_ready,
`ifdef DEMUX_PARITY_EN
  output logic [3:0]   sel,
  output logic         overrun,
  output logic         parity_err
`else
  output logic [2:0]   sel,
  output logic         overrun
`endif
);

`ifdef DEMUX_PARITY_EN
  localparam int SW   = 4;
  localparam int LAST = 8;
  localparam int AW   = 8;   // all 8 data bits are stored; parity bit is used live
`else
  localparam int SW   = 3;
  localparam int LAST = 7;
  localparam int AW   = 7;   // slot 7 is used live from sin, never stored
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_asm;
  logic [7:0]      r_q;
  logic            r_q_valid;
  logic            r_overrun;

  logic            w_acc;
  logic [SW-1:0]   w_slot;
  logic            w_done;
  logic            w_free;
  logic [7:0]      w_byte;

  // A bit is taken when valid and either synchronised or carrying a start.
  assign w_acc  = sin_valid & (sin_start | (r_state == S_RUN));
  // A start always restarts the frame at slot 0 (resync, partial discarded).
  assign w_slot = sin_start ? '0 : r_sel;
  assign w_done = w_acc & (w_slot == SW'(LAST));
  // Output register is free now or is being emptied on this same edge.
  assign w_free = ~r_q_valid | q_ready;

`ifdef DEMUX_PARITY_EN
  logic r_perr;
  assign w_byte     = r_asm;
  assign parity_err = r_perr;
`else
  assign w_byte     = {sin, r_asm};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_asm     <= '0;
      r_q       <= 8'h00;
      r_q_valid <= 1'b0;
      r_overrun <= 1'b0;
`ifdef DEMUX_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      if (r_q_valid & q_ready)
        r_q_valid <= 1'b0;
      if (w_acc) begin
        r_state <= S_RUN;
        for (int i = 0; i < AW; i++)
          if (w_slot == SW'(i)) r_asm[i] <= sin;
        r_sel <= (w_slot == SW'(LAST)) ? '0 : w_slot + SW'(1);
        if (w_done) begin
          if (w_free) begin
            r_q       <= w_byte;
            r_q_valid <= 1'b1;
`ifdef DEMUX_PARITY_EN
            r_perr    <= ^{r_asm, sin};
`endif
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign sel     = r_sel;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_demux_deser8.sv
module tb_demux_deser8;
`ifdef DEMUX_PARITY_EN
  localparam int SW = 4;
`else
  localparam int SW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst, sin, sin_valid, sin_start, q_ready;
  logic [7:0]    q;
  logic          q_valid, overrun;
  logic [SW-1:0] sel;
`ifdef DEMUX_PARITY_EN
  logic          parity_err;
  logic          exp_perr_q[$];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  demux_deser8 dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .sel(sel),
`ifdef DEMUX_PARITY_EN
    .overrun(overrun), .parity_err(parity_err)
`else
    .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when q_valid & q_ready.
  always @(negedge clk) begin
    if (!rst && q_valid && q_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none", q);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          n_fail++;
          $display("FAIL byte: got %0h expected %0h", q, e);
        end
`ifdef DEMUX_PARITY_EN
        if (exp_perr_q.size() != 0) begin
          logic pe;
          pe = exp_perr_q.pop_front();
          n_tests++;
          if (parity_err !== pe) begin
            n_fail++;
            $display("FAIL parity_err: got %0b expected %0b", parity_err, pe);
          end
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    sin = b; sin_valid = 1'b1; sin_start = st;
    tick();
    sin_valid = 1'b0; sin_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic st);
    for (int i = 0; i < 8; i++) send_bit(d[i], st && (i == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0; q_ready = 1'b1;
    tick(); tick(); rst = 1'b0;
    chk("rst_q", q, 8'h00);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_overrun", overrun, 0);

`ifndef DEMUX_PARITY_EN
    // 1: framed A5, q_ready high
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    chk("t1_q_valid_up", q_valid, 1);
    chk("t1_q", q, 8'hA5);
    chk("t1_sel", sel, 0);
    tick();
    chk("t1_q_valid_1cyc", q_valid, 0);

    // 2: unframed bits while IDLE are ignored (fresh reset -> IDLE)
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("t2_idle_sel", sel, 0);
    chk("t2_idle_q_valid", q_valid, 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    chk("t2_q", q, 8'h3C);
    tick(); tick();
    chk("t2_overrun", overrun, 0);

    // 3: second byte dropped while q held
    q_ready = 1'b0;
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b0);
    chk("t3_q_held", q, 8'h01);
    chk("t3_q_valid", q_valid, 1);
    chk("t3_overrun", overrun, 1);
    q_ready = 1'b1;
    tick();
    chk("t3_q_valid_fall", q_valid, 0);
    chk("t3_overrun_sticky", overrun, 1);

    // 4: ready on the exact completing edge of the second byte
    do_reset();
    chk("t4_overrun_cleared", overrun, 0);
    q_ready = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_byte(8'h01, 1'b1);
    d = 8'h80;
    for (int i = 0; i < 7; i++) send_bit(d[i], 1'b0);
    chk("t4_hold_q", q, 8'h01);
    q_ready = 1'b1;
    send_bit(d[7], 1'b0);
    chk("t4_q_new", q, 8'h80);
    chk("t4_q_valid_stays", q_valid, 1);
    chk("t4_no_overrun", overrun, 0);
    tick();

    // 5: resync mid-byte, then reset mid-byte
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("t5_partial_sel", sel, 3);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    chk("t5_q", q, 8'hFF);
    d = 8'h5A;
    for (int i = 0; i < 4; i++) send_bit(d[i], i == 0);
    chk("t5_sel4", sel, 4);
    sin = 1'b1; sin_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; sin_valid = 1'b0;
    chk("t5_rst_q", q, 8'h00);
    chk("t5_rst_q_valid", q_valid, 0);
    chk("t5_rst_sel", sel, 0);
    chk("t5_rst_overrun", overrun, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("t5_idle_after_rst", q_valid, 0);
`else
    // parity frames: 8'h07 + parity bit
    exp_q.push_back(8'h07); exp_perr_q.push_back(1'b0);
    send_byte(8'h07, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("p1_q", q, 8'h07);
    chk("p1_perr", parity_err, 0);
    chk("p1_sel", sel, 0);
    tick();
    exp_q.push_back(8'h07); exp_perr_q.push_back(1'b1);
    send_byte(8'h07, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("p2_q", q, 8'h07);
    chk("p2_perr", parity_err, 1);
    chk("p2_q_valid", q_valid, 1);
    tick();
`endif
    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
